cos_sweep_ctrl: RTL and testbench
=================================

Name: cos_sweep_ctrl

Overview:
- Initiator for the cosine unit's start/ready handshake: sweeps a sequence of fixed-point angles, issues one request per angle, and captures each result into an internal FIFO.
- Sits between host/bench logic and the cosine core, replacing hand-driven start pulses with a programmable sweep.
- Angles and results use the same 24-bit fixed-point format as the cosine core: 10 fractional bits, so 1.0 = 1024.

Parameters:
DATA_W, 24, angle/result width
DEPTH, 16, result FIFO entries (power of two)
START_HOLD, 3, cycles cos_start is held high per request
TIMEOUT, 255, max cycles waited for cos_ready per request

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
go  in  1  one-cycle pulse, starts a sweep
angle_base  in  DATA_W  first angle, sampled on go
angle_step  in  DATA_W  increment per point, sampled on go
num_points  in  8  points in sweep, sampled on go
busy  out  1  high from go acceptance until sweep ends
done  out  1  one-cycle pulse at sweep end
timeout_err  out  1  sticky; set on timeout, cleared by next accepted go
cos_start  out  1  request to cosine core
cos_angle  out  DATA_W  angle to cosine core, stable while request outstanding
cos_ready  in  1  completion from cosine core
cos_result  in  DATA_W  cosine value from core
rd_en  in  1  pop FIFO head
rd_data  out  DATA_W  FIFO head (show-ahead), valid when !empty
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: all outputs 0 except empty=1. State=IDLE, FIFO pointers 0, timeout_err=0. Reset mid-sweep aborts immediately; cos_start drops asynchronously; FIFO contents discarded.
- States: IDLE, CHECK, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: go=1 latches inputs, sets angle accumulator = angle_base, remaining = num_points, clears timeout_err, sets busy=1. Next state is CHECK, or DONE if num_points=0. go while busy is ignored.
- CHECK: if full, stay (stall, no request). Else drive cos_angle=accumulator and go to ISSUE.
- ISSUE: cos_start=1 for exactly START_HOLD cycles, then WAIT. cos_angle holds until CAPTURE completes.
- WAIT:
  - Rising edge of cos_ready is detected against its registered previous value; a level already high on entry does not count.
  - On detection go to CAPTURE.
  - Wait counter starts at 0 on entry. If it reaches TIMEOUT with no edge: set timeout_err and go to DONE; no FIFO write for that point.
- CAPTURE (1 cycle after edge detect): write cos_result into FIFO. accumulator += angle_step, modulo 2^DATA_W with silent wrap. remaining -= 1. If remaining=0 go to DONE, else CHECK.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Per-point latency: CHECK (1) + START_HOLD + core latency + edge detect (1) + CAPTURE (1).
- FIFO:
  - Show-ahead; rd_data = head whenever !empty.
  - rd_en with empty is ignored.
  - Simultaneous write and rd_en when full: the controller never writes when full, because CHECK stalls.
  - Simultaneous write and pop: level unchanged.
  - Pointers wrap modulo DEPTH.
- FIFO contents survive DONE and the next go. Reading is independent of sweep state.

Test Plan:
- Core model: ready 8 cycles after start falls, result = angle+1. Sweep base=0, step=512, num_points=4 -> FIFO holds 1, 513, 1025, 1537; done pulses once; cos_start high exactly 3 cycles per request.
- Wrap: base=0xFFFE00, step=0x000400, num_points=2 -> cos_angle sequence 0xFFFE00, 0x000200.
- Backpressure: DEPTH=16, num_points=20, no reads -> stall at full=1 with 16 entries, no cos_start. Pop 4 -> 4 remaining requests issued; all 20 values appear in order.
- Timeout: core never asserts ready -> timeout_err=1 after 255 WAIT cycles, done pulse, FIFO unchanged. Next go clears timeout_err.
- num_points=0 -> done pulses 2 cycles after go, no cos_start. go pulsed while busy -> ignored, sweep count unchanged.
- Reset asserted during WAIT -> cos_start=0, busy=0, empty=1 immediately. After release, a fresh sweep with num_points=1 completes normally.

Source files
------------

// File: rtl/cos_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// cos_sweep_ctrl
//
// Drives the cosine core's start/ready handshake over a programmable sweep
// of fixed-point angles and collects each result into a show-ahead FIFO.
// Angles and results share the core's format: DATA_W bits, 10 fractional
// bits (1.0 = 1024). Angle arithmetic wraps silently modulo 2^DATA_W.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   go           one-cycle pulse; starts a sweep when idle, ignored when busy
//   angle_base   first angle, sampled on an accepted go
//   angle_step   per-point angle increment, sampled on an accepted go
//   num_points   points in the sweep (0 = empty sweep), sampled on go
//   busy         high from go acceptance until the sweep ends
//   done         one-cycle pulse at sweep end
//   timeout_err  sticky; set when the core fails to answer, cleared by go
//   cos_start    request to the cosine core, held START_HOLD cycles
//   cos_angle    angle presented to the core, stable while a request is open
//   cos_ready    completion from the core (rising edge is the event)
//   cos_result   result from the core
//   rd_en        pop the FIFO head (ignored when empty)
//   rd_data      FIFO head, valid whenever !empty (0 when empty)
//   empty/full   FIFO status
//   level        FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cos_sweep_ctrl #(
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 16,
  parameter int START_HOLD = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  logic [DATA_W-1:0]       angle_base,
  input  logic [DATA_W-1:0]       angle_step,
  input  logic [7:0]              num_points,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic                    cos_start,
  output logic [DATA_W-1:0]       cos_angle,
  input  logic                    cos_ready,
  input  logic [DATA_W-1:0]       cos_result,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   acc;        // angle of the point being processed
  logic [DATA_W-1:0]   step_q;     // increment latched on go
  logic [DATA_W-1:0]   result_q;   // core result latched on the ready edge
  logic [7:0]          remaining;  // points not yet captured
  logic [HOLD_W-1:0]   hold_cnt;   // cycles cos_start has been high
  logic [WCNT_W-1:0]   wait_cnt;   // cycles spent waiting for ready
  logic                ready_q;    // cos_ready one cycle ago
  logic                ready_edge;

  // FIFO storage and pointers
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                fifo_wr;
  logic                do_wr;
  logic                do_rd;

  // Only a low-to-high transition counts: a ready level left over from a
  // previous request, or already high when WAIT is entered, is not a
  // completion.
  assign ready_edge = cos_ready & ~ready_q;

  // The write happens on the edge that leaves CAPTURE. CHECK refuses to
  // issue while full and pops only ever lower the level, so the full guard
  // never actually blocks a capture.
  assign fifo_wr = (state == S_CAPTURE);
  assign do_wr   = fifo_wr & ~full;
  assign do_rd   = rd_en & ~empty;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));

  // NOTE: continuous assigns and always_comb cover every case with a
  // defined value, so no path can hold an old value and infer a latch.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // -------------------------------------------------------------------------
  // Sweep sequencer. All handshake and status outputs are registered here so
  // they are glitch-free and cos_start drops as soon as reset is asserted.
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cos_start   <= 1'b0;
      cos_angle   <= '0;
      acc         <= '0;
      step_q      <= '0;
      result_q    <= '0;
      remaining   <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= cos_ready;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go) begin
            acc         <= angle_base;
            step_q      <= angle_step;
            remaining   <= num_points;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= (num_points == 8'd0) ? S_DONE : S_CHECK;
          end
        end

        // Stall here while the FIFO has no room for the result.
        S_CHECK: begin
          if (!full) begin
            cos_angle <= acc;
            cos_start <= 1'b1;
            hold_cnt  <= '0;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
            cos_start <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        // A timeout abandons the rest of the sweep; nothing is written for
        // the unanswered point.
        S_WAIT: begin
          if (ready_edge) begin
            result_q <= cos_result;
            state    <= S_CAPTURE;
          end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end

        S_CAPTURE: begin
          acc       <= acc + step_q;
          remaining <= remaining - 8'd1;
          state     <= (remaining == 8'd1) ? S_DONE : S_CHECK;
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO bookkeeping. Pointers wrap naturally at DEPTH (power of two);
  // level tracks occupancy and is unchanged by a simultaneous push and pop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and level
  // already makes every entry unreachable, and a reset here would turn the
  // array into a large bank of resettable flops.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= result_q;
  end

endmodule

// File: tb/tb_cos_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cos_sweep_ctrl
//
// Bench for cos_sweep_ctrl. A behavioural cosine core answers each request
// after a programmable latency with result = angle + 1. The reference model
// lists, per sweep, the angles that must be requested and the results that
// must come out of the FIFO (angle_i = base + i*step mod 2^DATA_W), and the
// monitors compare the DUT's traffic against those lists.
// ---------------------------------------------------------------------------
module tb_cos_sweep_ctrl;

  localparam int DATA_W     = 24;
  localparam int DEPTH      = 16;
  localparam int START_HOLD = 3;
  localparam int TIMEOUT    = 255;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   go = 1'b0;
  logic [DATA_W-1:0]      angle_base = '0;
  logic [DATA_W-1:0]      angle_step = '0;
  logic [7:0]             num_points = '0;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;
  logic                   cos_start;
  logic [DATA_W-1:0]      cos_angle;
  logic                   cos_ready = 1'b0;
  logic [DATA_W-1:0]      cos_result = '0;
  logic                   rd_en = 1'b0;
  logic [DATA_W-1:0]      rd_data;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] level;

  always #5 clock = ~clock;

  cos_sweep_ctrl #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .START_HOLD (START_HOLD),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .angle_base  (angle_base),
    .angle_step  (angle_step),
    .num_points  (num_points),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .cos_start   (cos_start),
    .cos_angle   (cos_angle),
    .cos_ready   (cos_ready),
    .cos_result  (cos_result),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .level       (level)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] exp_angle[$];   // angles still to be requested
  logic [DATA_W-1:0] exp_res[$];     // results still to be read out
  bit  core_en     = 1'b1;
  int  core_lat    = 8;
  int  start_count = 0;
  int  done_count  = 0;
  int  pops_wanted = 0;
  bit  rd_random   = 1'b0;

  function automatic logic [DATA_W-1:0] angle_at(input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] s,
                                                 input int i);
    longint t;
    t = longint'(b) + longint'(s) * longint'(i);
    return DATA_W'(t);
  endfunction

  task automatic push_points(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] s,
                             input int n, input bit with_results);
    for (int i = 0; i < n; i++) begin
      exp_angle.push_back(angle_at(b, s, i));
      if (with_results) exp_res.push_back(angle_at(b, s, i) + DATA_W'(1));
    end
  endtask

  // Step to just after the next falling edge, once all monitors have run.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_go(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] s,
                          input logic [7:0] n);
    tick();
    angle_base = b;
    angle_step = s;
    num_points = n;
    go         = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int k;
    k = 0;
    while (done_count == d0 && k < bound) begin
      tick();
      k++;
    end
    check("done_seen", 64'(done_count > d0), 64'(1));
    tick();
    check("done_once", 64'(done_count - d0), 64'(1));
    check("busy_after_done", 64'(busy), 64'(0));
    check("all_angles_issued", 64'(exp_angle.size()), 64'(0));
  endtask

  task automatic drain();
    int k;
    k = 0;
    pops_wanted = exp_res.size();
    while (pops_wanted > 0 && k < 200) begin
      tick();
      k++;
    end
    check("drain_complete", 64'(pops_wanted), 64'(0));
    tick();
    check("drain_empty", 64'(empty), 64'(1));
    check("drain_level", 64'(level), 64'(0));
  endtask

  // ---------------- behavioural cosine core ----------------
  int                core_cnt  = -1;
  bit                core_prev = 1'b0;
  logic [DATA_W-1:0] core_angle = '0;

  always @(negedge clock) begin
    if (reset) begin
      core_cnt  = -1;
      core_prev = 1'b0;
      cos_ready = 1'b0;
    end else begin
      cos_ready = 1'b0;
      if (core_prev && !cos_start) begin
        if (core_en) begin
          core_cnt   = core_lat - 1;
          core_angle = cos_angle;
        end
      end else if (core_cnt == 0) begin
        check("angle_stable", 64'(cos_angle), 64'(core_angle));
        cos_ready  = 1'b1;
        cos_result = core_angle + DATA_W'(1);
        core_cnt   = -1;
      end else if (core_cnt > 0) begin
        core_cnt--;
      end
      core_prev = cos_start;
    end
  end

  // ---------------- request / done monitor ----------------
  int hi_cnt   = 0;
  bit mon_prev = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      hi_cnt   = 0;
      mon_prev = 1'b0;
    end else begin
      if (cos_start && !mon_prev) begin
        start_count++;
        hi_cnt = 1;
        check("start_expected", 64'(exp_angle.size() != 0), 64'(1));
        if (exp_angle.size() != 0) check("start_angle", 64'(cos_angle), 64'(exp_angle.pop_front()));
      end else if (cos_start) begin
        hi_cnt++;
      end else if (mon_prev) begin
        check("start_width", 64'(hi_cnt), 64'(START_HOLD));
      end
      if (done) done_count++;
      mon_prev = cos_start;
    end
  end

  // ---------------- FIFO reader ----------------
  always @(negedge clock) begin
    if (reset) begin
      rd_en = 1'b0;
    end else begin
      rd_en = 1'b0;
      if (pops_wanted > 0 || (rd_random && $urandom_range(0, 1) == 1)) begin
        rd_en = 1'b1;  // also exercises pops against an empty FIFO
        if (!empty) begin
          check("fifo_data_expected", 64'(exp_res.size() != 0), 64'(1));
          if (exp_res.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_res.pop_front()));
          if (pops_wanted > 0) pops_wanted--;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, s0, k;
    logic [DATA_W-1:0] b, s;
    int n;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    check("rst_cos_start", 64'(cos_start), 64'(0));
    check("rst_cos_angle", 64'(cos_angle), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    reset = 1'b0;
    tick();

    // Basic sweep: 0, 512, 1024, 1536 -> results 1, 513, 1025, 1537
    core_lat = 8;
    d0 = done_count;
    s0 = start_count;
    push_points(24'd0, 24'd512, 4, 1'b1);
    pulse_go(24'd0, 24'd512, 8'd4);
    check("basic_busy", 64'(busy), 64'(1));
    wait_done(d0, 400);
    check("basic_starts", 64'(start_count - s0), 64'(4));
    check("basic_level", 64'(level), 64'(4));
    drain();

    // Angle wrap: 0xFFFE00, 0x000200; left in the FIFO across later sweeps
    d0 = done_count;
    push_points(24'hFFFE00, 24'h000400, 2, 1'b1);
    pulse_go(24'hFFFE00, 24'h000400, 8'd2);
    wait_done(d0, 200);
    check("wrap_level", 64'(level), 64'(2));

    // Timeout: core silent; only the first point is requested
    core_en = 1'b0;
    d0 = done_count;
    push_points(24'h001234, 24'h000010, 1, 1'b0);
    pulse_go(24'h001234, 24'h000010, 8'd3);
    k = 0;
    while (!cos_start && k < 50) begin tick(); k++; end
    check("to_start_seen", 64'(cos_start), 64'(1));
    k = 0;
    while (cos_start && k < 50) begin tick(); k++; end
    k = 0;
    while (!timeout_err && k < 400) begin tick(); k++; end
    check("to_wait_cycles", 64'(k), 64'(TIMEOUT));
    wait_done(d0, 20);
    check("to_sticky", 64'(timeout_err), 64'(1));
    check("to_fifo_unchanged", 64'(level), 64'(2));
    core_en = 1'b1;

    // Empty sweep: done two cycles after go, no request; go clears the error
    d0 = done_count;
    s0 = start_count;
    pulse_go(24'd5, 24'd5, 8'd0);
    check("zero_busy", 64'(busy), 64'(1));
    check("zero_done_early", 64'(done), 64'(0));
    check("to_cleared_by_go", 64'(timeout_err), 64'(0));
    tick();
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy_low", 64'(busy), 64'(0));
    tick();
    check("zero_done_count", 64'(done_count - d0), 64'(1));
    check("zero_no_start", 64'(start_count - s0), 64'(0));
    drain();  // wrap results survive the timeout sweep and the next go

    // go while busy is ignored
    d0 = done_count;
    s0 = start_count;
    push_points(24'h000777, 24'h000055, 3, 1'b1);
    pulse_go(24'h000777, 24'h000055, 8'd3);
    repeat (5) tick();
    pulse_go(24'h000ABC, 24'h000001, 8'd5);
    wait_done(d0, 400);
    check("busy_go_starts", 64'(start_count - s0), 64'(3));
    drain();

    // Backpressure: 20 points into a 16-entry FIFO with no reads
    d0 = done_count;
    push_points(24'h000100, 24'h000003, 20, 1'b1);
    pulse_go(24'h000100, 24'h000003, 8'd20);
    k = 0;
    while (!full && k < 2000) begin tick(); k++; end
    check("bp_full", 64'(full), 64'(1));
    s0 = start_count;
    repeat (40) tick();
    check("bp_no_start", 64'(start_count - s0), 64'(0));
    check("bp_level", 64'(level), 64'(DEPTH));
    check("bp_busy", 64'(busy), 64'(1));
    pops_wanted = 4;
    k = 0;
    while (pops_wanted > 0 && k < 50) begin tick(); k++; end
    wait_done(d0, 1000);
    check("bp_resumed_starts", 64'(start_count - s0), 64'(4));
    check("bp_level_end", 64'(level), 64'(DEPTH));
    drain();

    // Reset during WAIT with stale FIFO contents
    d0 = done_count;
    push_points(24'h000040, 24'h000040, 2, 1'b1);
    pulse_go(24'h000040, 24'h000040, 8'd2);
    wait_done(d0, 200);
    push_points(24'h000900, 24'h000008, 3, 1'b1);
    pulse_go(24'h000900, 24'h000008, 8'd3);
    k = 0;
    while (!cos_start && k < 50) begin tick(); k++; end
    k = 0;
    while (cos_start && k < 50) begin tick(); k++; end
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_cos_start", 64'(cos_start), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_empty", 64'(empty), 64'(1));
    check("rst_mid_level", 64'(level), 64'(0));
    exp_angle.delete();
    exp_res.delete();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    d0 = done_count;
    push_points(24'h000321, 24'h000005, 1, 1'b1);
    pulse_go(24'h000321, 24'h000005, 8'd1);
    wait_done(d0, 200);
    check("rst_fresh_level", 64'(level), 64'(1));
    drain();

    // Randomised sweeps with random core latency and random reads
    for (int t = 0; t < 8; t++) begin
      core_lat  = int'($urandom_range(1, 12));
      b         = DATA_W'($urandom);
      s         = DATA_W'($urandom);
      n         = int'($urandom_range(1, 12));
      rd_random = 1'b1;
      d0 = done_count;
      push_points(b, s, n, 1'b1);
      pulse_go(b, s, 8'(n));
      wait_done(d0, 2000);
      rd_random = 1'b0;
      tick();
      tick();
      check("rand_level", 64'(level), 64'(exp_res.size()));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
